// File: rtl/unique_filter_if.sv
// Stream bundle for unique_filter: sample input, emitted-value output and run status.
// The master side feeds samples and consumes outputs; the slave side is the filter.
interface unique_filter_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W:0]   out_idx;
  logic              out_ready;
  logic              dup_flag;
  logic [DATA_W:0]   count;
  logic              done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, dup_flag, count, done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, dup_flag, count, done
  );
endinterface

// File: rtl/unique_filter.sv
// Passes through the first occurrence of each sample value, in arrival order,
// until N_OUT distinct values have been emitted; repeats are dropped with a pulse.
module unique_filter #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 1 << DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  unique_filter_if.slave bus
);
  localparam int            DEPTH = 1 << DATA_W;
  localparam int            CW    = DATA_W + 1;
  localparam logic [CW-1:0] LAST  = CW'(N_OUT);

  typedef enum logic {RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  bitmap_q, bitmap_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              dup_q, dup_d;

  logic              in_ready;
  logic              accept;
  logic              fresh;
  logic [CW-1:0]     count_inc;

  // rst_n gates in_ready so nothing looks acceptable while reset is held.
  assign in_ready  = rst_n && (state_q == RUN) && !clear &&
                     (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign fresh     = accept && !bitmap_q[bus.in_data];
  assign count_inc = count_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    bitmap_d    = bitmap_q;
    count_d     = count_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    dup_d       = 1'b0;
    if (clear) begin
      // A pending output is discarded along with the run history.
      state_d     = RUN;
      bitmap_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
      if (fresh) begin
        bitmap_d[bus.in_data] = 1'b1;
        out_data_d            = bus.in_data;
        out_idx_d             = count_q;
        out_valid_d           = 1'b1;
        count_d               = count_inc;
        if (count_inc == LAST) state_d = DONE;
      end
      if (accept && !fresh) dup_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      bitmap_q    <= '0;
      count_q     <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      count_q     <= count_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      dup_q       <= dup_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.dup_flag  = dup_q;
  assign bus.count     = count_q;
  assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_unique_filter.sv
// Bench for unique_filter: directed table on an 8-bit instance, hand sequences for
// reset/N_OUT limits, and a random run on a 4-bit instance against a list-based model.
module tb_unique_filter;
  logic clk;
  logic rst8, rst4, rst3;
  logic clr8, clr4, clr3;

  unique_filter_if #(.DATA_W(8)) b8 ();
  unique_filter_if #(.DATA_W(4)) b4 ();
  unique_filter_if #(.DATA_W(8)) b3 ();

  unique_filter #(.DATA_W(8))              d8 (.clk(clk), .rst_n(rst8), .clear(clr8), .bus(b8.slave));
  unique_filter #(.DATA_W(4), .N_OUT(16))  d4 (.clk(clk), .rst_n(rst4), .clear(clr4), .bus(b4.slave));
  unique_filter #(.DATA_W(8), .N_OUT(3))   d3 (.clk(clk), .rst_n(rst3), .clear(clr3), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  typedef struct {
    bit clr, iv, ordy;
    int d;
    bit ir, ov, dup;
    int od, oi, cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit clr, bit iv, int d, bit ordy, bit ir, bit ov,
                              int od, int oi, bit dup, int cnt);
    vec_t v;
    v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.oi = oi; v.dup = dup; v.cnt = cnt;
    return v;
  endfunction

  // Reference model for the 4-bit instance: the ordered list of values emitted so far
  // in this run, plus the currently presented output.
  int emitted[$];
  int seen_log[$];
  bit m_ov, m_dup;
  int m_od, m_oi;

  function automatic bit in_list(int v);
    foreach (emitted[i]) if (emitted[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc4(input bit clr, input bit iv, input int d, input bit ordy);
    bit exp_ir, acc, is_new;
    b4.in_valid  = iv;
    b4.in_data   = d[3:0];
    b4.out_ready = ordy;
    clr4         = clr;
    @(negedge clk);
    exp_ir = (emitted.size() < 16) && !clr && (!m_ov || ordy);
    chk("u4 in_ready",  b4.in_ready,  exp_ir);
    chk("u4 out_valid", b4.out_valid, m_ov);
    chk("u4 dup_flag",  b4.dup_flag,  m_dup);
    chk("u4 count",     b4.count,     emitted.size());
    chk("u4 done",      b4.done,      emitted.size() == 16);
    if (m_ov) begin
      chk("u4 out_data", b4.out_data, m_od);
      chk("u4 out_idx",  b4.out_idx,  m_oi);
    end
    if (b4.out_valid && ordy && !clr) seen_log.push_back(int'(b4.out_data));
    if (clr) begin
      emitted.delete();
      m_ov  = 1'b0;
      m_dup = 1'b0;
    end else begin
      acc    = iv && exp_ir;
      is_new = acc && !in_list(d);
      m_dup  = acc && !is_new;
      if (is_new) begin
        emitted.push_back(d);
        m_od = d;
        m_oi = emitted.size() - 1;
        m_ov = 1'b1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic step3(input bit clr, input bit iv, input int d, input bit ordy);
    clr3         = clr;
    b3.in_valid  = iv;
    b3.in_data   = d[7:0];
    b3.out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    int cycles;
    int mask;
    vec_t v;

    {rst8, rst4, rst3} = 3'b000;
    {clr8, clr4, clr3} = 3'b000;
    b8.in_valid = 1'b1; b8.in_data = 8'd0; b8.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = 4'd0; b4.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = 8'd0; b3.out_ready = 1'b0;
    m_ov = 1'b0; m_dup = 1'b0; m_od = 0; m_oi = 0;

    // Reset state, including in_ready held low while rst_n is low.
    @(negedge clk);
    chk("rst in_ready",  b8.in_ready,  0);
    chk("rst out_valid", b8.out_valid, 0);
    chk("rst out_data",  b8.out_data,  0);
    chk("rst out_idx",   b8.out_idx,   0);
    chk("rst dup_flag",  b8.dup_flag,  0);
    chk("rst count",     b8.count,     0);
    chk("rst done",      b8.done,      0);
    b8.in_valid = 1'b0;
    @(posedge clk); #1;
    {rst8, rst4, rst3} = 3'b111;

    // Directed table: 5,5,0,5,7 stream; back-pressure; clear vs unique 9; value 0/255.
    tbl.push_back(mk(0,1,5,1,   1,1,5,0,0,1));
    tbl.push_back(mk(0,1,5,1,   1,0,0,0,1,1));
    tbl.push_back(mk(0,1,0,1,   1,1,0,1,0,2));
    tbl.push_back(mk(0,1,5,1,   1,0,0,0,1,2));
    tbl.push_back(mk(0,1,7,1,   1,1,7,2,0,3));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,8,0, 0,1,7,2,0,3));
    tbl.push_back(mk(0,1,8,1,   1,1,8,3,0,4));
    tbl.push_back(mk(0,1,9,1,   1,1,9,4,0,5));
    tbl.push_back(mk(0,1,10,1,  1,1,10,5,0,6));
    tbl.push_back(mk(1,1,9,1,   0,0,0,0,0,0));
    tbl.push_back(mk(0,1,9,1,   1,1,9,0,0,1));
    tbl.push_back(mk(0,1,0,1,   1,1,0,1,0,2));
    tbl.push_back(mk(0,1,255,1, 1,1,255,2,0,3));
    tbl.push_back(mk(0,0,0,1,   1,0,0,0,0,3));

    foreach (tbl[i]) begin
      v = tbl[i];
      clr8 = v.clr; b8.in_valid = v.iv; b8.in_data = v.d[7:0]; b8.out_ready = v.ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d in_ready", i), b8.in_ready, v.ir);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d out_valid", i), b8.out_valid, v.ov);
      chk($sformatf("tbl%0d dup_flag", i),  b8.dup_flag,  v.dup);
      chk($sformatf("tbl%0d count", i),     b8.count,     v.cnt);
      chk($sformatf("tbl%0d done", i),      b8.done,      0);
      if (v.ov) begin
        chk($sformatf("tbl%0d out_data", i), b8.out_data, v.od);
        chk($sformatf("tbl%0d out_idx", i),  b8.out_idx,  v.oi);
      end
    end
    clr8 = 1'b0; b8.in_valid = 1'b0;

    // Asynchronous reset pulse between edges after 3 uniques (9,0,255).
    #2 rst8 = 1'b0;
    #1;
    chk("async rst count",     b8.count,     0);
    chk("async rst out_valid", b8.out_valid, 0);
    chk("async rst in_ready",  b8.in_ready,  0);
    chk("async rst done",      b8.done,      0);
    #2 rst8 = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b1; b8.in_data = 8'd9; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    chk("post rst out_valid", b8.out_valid, 1);
    chk("post rst out_data",  b8.out_data,  9);
    chk("post rst out_idx",   b8.out_idx,   0);
    chk("post rst dup_flag",  b8.dup_flag,  0);
    chk("post rst count",     b8.count,     1);

    // N_OUT=3 instance: stream 1,1,2,3,4.
    step3(0,1,1,1);
    step3(0,1,1,1);
    chk("n3 dup pulse", b3.dup_flag, 1);
    step3(0,1,2,1);
    chk("n3 dup cleared", b3.dup_flag, 0);
    step3(0,1,3,1);
    chk("n3 done",      b3.done,      1);
    chk("n3 count",     b3.count,     3);
    chk("n3 last data", b3.out_data,  3);
    chk("n3 last idx",  b3.out_idx,   2);
    chk("n3 last vld",  b3.out_valid, 1);
    b3.in_data = 8'd4;
    @(negedge clk);
    chk("n3 in_ready in DONE", b3.in_ready, 0);
    @(posedge clk); #1;
    chk("n3 count held",      b3.count,     3);
    chk("n3 drained",         b3.out_valid, 0);
    chk("n3 still done",      b3.done,      1);
    chk("n3 no dup in DONE",  b3.dup_flag,  0);
    step3(1,1,4,1);
    chk("n3 clear count", b3.count, 0);
    chk("n3 clear done",  b3.done,  0);
    chk("n3 clear vld",   b3.out_valid, 0);
    step3(0,1,4,1);
    chk("n3 restart data", b3.out_data,  4);
    chk("n3 restart idx",  b3.out_idx,   0);
    chk("n3 restart vld",  b3.out_valid, 1);
    step3(0,0,0,1);

    // 4-bit random run to completion: 16 distinct outputs, then DONE.
    cycles = 0;
    while (!(emitted.size() == 16 && !m_ov) && cycles < 3000) begin
      cyc4(1'b0, ($urandom % 5) != 0, int'($urandom % 16), ($urandom % 4) != 0);
      cycles++;
    end
    chk("u4 run finished in budget", cycles < 3000, 1);
    cyc4(1'b0, 1'b1, 3, 1'b1);
    chk("u4 final in_ready", b4.in_ready, 0);
    chk("u4 final done",     b4.done,     1);
    chk("u4 final count",    b4.count,    16);
    chk("u4 output total", seen_log.size(), 16);
    mask = 0;
    foreach (seen_log[i]) mask |= (1 << seen_log[i]);
    chk("u4 permutation mask", mask, 32'h0000_FFFF);

    // Random traffic with occasional clears, checked cycle by cycle.
    cyc4(1'b1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 400; i++)
      cyc4(($urandom % 40) == 0, ($urandom % 4) != 0, int'($urandom % 16), ($urandom % 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
